store_conv: RTL and testbench
=============================

# store_conv

Store-path data converter and memory writer for the MIPS load/store unit, the write-direction counterpart of the load data converter. Takes a store request (base, 16-bit offset, register data, store function), computes the effective byte address, and performs either a direct word write or a read-modify-write on the word-wide data memory for byte, halfword and unaligned-left/right stores. Sits between the execute stage and the data memory port; it stalls the pipeline through `busy` and reports completion through `done` and `err`.

## Interface
- `TIMEOUT`, 255: memory handshake watchdog limit in cycles; used only with `STORE_CONV_TIMEOUT_EN`; 1..65535.

- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  1  store request; accepted when high and `busy`=0.
- `func`  in  3  store type: 000 sb, 001 sh, 010 swl, 011 sw, 110 swr; 100/101/111 illegal.
- `base`  in  32  base register value.
- `offset`  in  16  signed immediate.
- `rin`  in  32  register data to store.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned, illegal func, or timeout.
- `mem_addr`  out  30  word address [31:2].
- `mem_rd`  out  1  read request.
- `mem_rdata`  in  32  read data.
- `mem_rvalid`  in  1  read data valid / read handshake.
- `mem_wr`  out  1  write request.
- `mem_wdata`  out  32  write data.
- `mem_wready`  in  1  write accepted.

## Operation
- Effective address A = base + sign-extended offset, 32-bit wrap-around; `mem_addr`=A[31:2], lane k=A[1:0]. All inputs captured on acceptance; may change afterwards.
- Little-endian lanes: byte k at bits [8k+7:8k].
- sb: byte k ← rin[7:0]. sh: bytes k,k+1 ← rin[15:0]; k odd → err. sw: word ← rin; k≠0 → err.
- swl at k: memory bytes 0..k ← rin's top k+1 bytes (byte 0 ← rin[31-8k:24-8k] ... byte k ← rin[31:24]); k=3 is full word.
- swr at k: memory bytes k..3 ← rin[31-8k:0]; k=0 is full word.
- Full-word cases (sw, swl k=3, swr k=0) skip READ. Partial cases merge mem_rdata with rin lanes.
- Errors (misaligned, illegal func): no `mem_rd`/`mem_wr` issued; `done`=`err`=1 cycle after acceptance.
- FSM: IDLE → READ (partial) or WRITE (full word) or IDLE with done+err (error). READ: `mem_rd`=1 until `mem_rvalid`; merged data registered, → WRITE. WRITE: `mem_wr`=1 until `mem_wready`, → IDLE with `done`=1.
- `busy`=1 in READ and WRITE only; a new `req` is accepted in the cycle `done` is high (back-to-back).
- `mem_rvalid` outside READ and `mem_wready` outside WRITE are ignored.

## Timing
- Reset: state IDLE; `busy`, `done`, `err`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_wdata` = 0.
- Full-word min latency: req cycle 0, WRITE cycle 1, done cycle 2. Partial: READ cycle 1, WRITE cycle 2, done cycle 3. Error: done cycle 1.
- Each wait cycle adds one cycle; `mem_addr` stable across READ+WRITE, `mem_wdata` stable throughout WRITE.
- `done`, `err` registered, high exactly one cycle; `err`=0 whenever `done`=0.
- `rst` mid-operation: next edge IDLE, `mem_rd`/`mem_wr` drop, no `done` pulse.

## Configuration
- `STORE_CONV_TIMEOUT_EN` defined: counter cleared on entering READ/WRITE, incremented each wait cycle; after `TIMEOUT` consecutive cycles without handshake, abort to IDLE with `done`=`err`=1, `mem_rd`/`mem_wr` deasserted, no write issued.
- Undefined: no counter; READ/WRITE wait indefinitely; `TIMEOUT` ignored.

## Test plan
- sb base=4 off=1 rin=aabbccdd, memory 11223344, zero wait → mem_rd addr 1 cycle 1, mem_wdata 1122dd44 cycle 2, done=1 err=0 cycle 3.
- sh off=2 same data → wdata ccdd3344; sh off=1 → done+err cycle 1, mem_rd/mem_wr never asserted; func=111 → same.
- swl k=1 rin=aabbccdd mem 11223344 → 1122aabb; swr k=1 → bbccdd44; swl k=3 / swr k=0 → no read, wdata aabbccdd.
- sw base=fffffffc off=4 rin=deadbeef → mem_addr 0, no read, wdata deadbeef; wready low 3 cycles → wdata/addr stable, done cycle after handshake; new req during done accepted.
- With `STORE_CONV_TIMEOUT_EN`, TIMEOUT=4, sb with rvalid never asserted → mem_rd high 4 cycles, then done+err, no write; rst asserted mid-READ on another run → IDLE, no done.

Source files
------------

// File: rtl/store_conv.sv
// Store-path converter: effective address, lane placement and read-modify-write into word memory.
// Optional handshake watchdog is enabled by defining STORE_CONV_TIMEOUT_EN.
module store_conv #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [2:0]         func,
  input  logic [31:0]        base,
  input  logic signed [15:0] offset,
  input  logic [31:0]        rin,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [29:0]        mem_addr,
  output logic               mem_rd,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rvalid,
  output logic               mem_wr,
  output logic [31:0]        mem_wdata,
  input  logic               mem_wready
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t      state;
  logic [2:0]  func_q;
  logic [1:0]  lane_q;
  logic [31:0] rin_q;
  logic [31:0] ea;
  logic        bad;
  logic        full;

  assign ea = base + {{16{offset[15]}}, offset};

  // Byte lanes of the memory word that the store overwrites.
  function automatic logic [3:0] lane_mask(input logic [2:0] f, input logic [1:0] k);
    case (f)
      3'b000:  lane_mask = 4'b0001 << k;
      3'b001:  lane_mask = 4'b0011 << k;
      3'b010:  lane_mask = 4'b1111 >> ~k;
      3'b110:  lane_mask = 4'b1111 << k;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Register data moved into its memory lanes; swl takes rin's top bytes, swr its low bytes.
  function automatic logic [31:0] lane_data(input logic [2:0] f, input logic [1:0] k,
                                            input logic [31:0] r);
    case (f)
      3'b000:  lane_data = {4{r[7:0]}};
      3'b001:  lane_data = {2{r[15:0]}};
      3'b010:  lane_data = r >> {~k, 3'b000};
      3'b110:  lane_data = r << {k, 3'b000};
      default: lane_data = r;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [3:0] m, input logic [31:0] d,
                                        input logic [31:0] old);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    bad  = 1'b0;
    full = 1'b0;
    case (func)
      3'b000:  bad  = 1'b0;
      3'b001:  bad  = ea[0];
      3'b010:  full = (ea[1:0] == 2'd3);
      3'b011:  begin
        bad  = (ea[1:0] != 2'd0);
        full = 1'b1;
      end
      3'b110:  full = (ea[1:0] == 2'd0);
      default: bad  = 1'b1;
    endcase
  end

`ifdef STORE_CONV_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        expired;
  assign expired = (wait_cnt == 16'(TIMEOUT - 1));
`else
  // TIMEOUT only sizes the watchdog; nothing to build without it.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef STORE_CONV_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            func_q <= func;
            lane_q <= ea[1:0];
            rin_q  <= rin;
`ifdef STORE_CONV_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (bad) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              busy     <= 1'b1;
              mem_addr <= ea[31:2];
              if (full) begin
                state     <= S_WRITE;
                mem_wr    <= 1'b1;
                mem_wdata <= rin;
              end else begin
                state  <= S_READ;
                mem_rd <= 1'b1;
              end
            end
          end
        end
        S_READ: begin
          if (mem_rvalid) begin
            state     <= S_WRITE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b1;
            mem_wdata <= merge(lane_mask(func_q, lane_q), lane_data(func_q, lane_q, rin_q),
                               mem_rdata);
`ifdef STORE_CONV_TIMEOUT_EN
            wait_cnt  <= '0;
          end else if (expired) begin
            state  <= S_IDLE;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        S_WRITE: begin
          if (mem_wready) begin
            state  <= S_IDLE;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
`ifdef STORE_CONV_TIMEOUT_EN
          end else if (expired) begin
            state  <= S_IDLE;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_conv.sv
// Directed-vector bench for store_conv with a cycle-driven memory responder.
module tb_store_conv;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [2:0]  func;
  logic [31:0] base, rin;
  logic [15:0] offset;
  logic        busy, done, err;
  logic [29:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata, mem_wdata;
  logic        mem_rvalid, mem_wready;

  int checks = 0;
  int errors = 0;

  int          rd_cyc, nrd, wr_cyc, nwr, done_cyc;
  logic [29:0] rd_addr, wr_addr;
  logic [31:0] wdata;
  logic        err_v, unstable;

  store_conv #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .func(func), .base(base), .offset(offset),
    .rin(rin), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wready(mem_wready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request at the current time and services memory until done (40-cycle bound).
  // rw/ww: wait cycles before rvalid/wready; negative means never respond.
  task automatic run(input logic [2:0] f, input logic [31:0] b, input logic [15:0] o,
                     input logic [31:0] r, input logic [31:0] m, input int rw, input int ww);
    rd_cyc = -1; nrd = 0; wr_cyc = -1; nwr = 0; done_cyc = -1;
    rd_addr = '0; wr_addr = '0; wdata = '0; err_v = 1'b0; unstable = 1'b0;
    req = 1'b1; func = f; base = b; offset = o; rin = r;
    @(posedge clk); #1;
    req = 1'b0; func = 3'b101; base = $urandom; offset = 16'($urandom); rin = $urandom;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      if (mem_rd) begin
        if (nrd == 0) begin
          rd_cyc  = cyc;
          rd_addr = mem_addr;
        end
        nrd++;
      end
      mem_rdata  = m;
      mem_rvalid = mem_rd && rw >= 0 && nrd > rw;
      if (mem_wr) begin
        if (nwr == 0) begin
          wr_cyc  = cyc;
          wr_addr = mem_addr;
          wdata   = mem_wdata;
        end else if (mem_wdata !== wdata || mem_addr !== wr_addr) begin
          unstable = 1'b1;
        end
        nwr++;
      end
      mem_wready = mem_wr && ww >= 0 && nwr > ww;
      if (done) begin
        done_cyc = cyc;
        err_v    = err;
      end else begin
        @(posedge clk); #1;
      end
    end
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("err_one_cycle", {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req = 1'b0; func = 3'b000; base = '0; offset = '0; rin = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_addr", {2'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(3'b000, 32'd4, 16'd1, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("sb_rd_cyc", rd_cyc, 1);
    chk("sb_rd_addr", {2'd0, rd_addr}, 32'd1);
    chk("sb_wr_cyc", wr_cyc, 2);
    chk("sb_wdata", wdata, 32'h1122dd44);
    chk("sb_done_cyc", done_cyc, 3);
    chk("sb_err", {31'd0, err_v}, 32'd0);
    idle_cycle();

    run(3'b001, 32'd4, 16'd2, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("sh_wdata", wdata, 32'hccdd3344);
    chk("sh_done_cyc", done_cyc, 3);
    idle_cycle();

    run(3'b001, 32'h100, 16'hfffe, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("sh_neg_addr", {2'd0, wr_addr}, 32'h3f);
    chk("sh_neg_wdata", wdata, 32'hccdd3344);
    idle_cycle();

    run(3'b001, 32'd4, 16'd1, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("sh_mis_done_cyc", done_cyc, 1);
    chk("sh_mis_err", {31'd0, err_v}, 32'd1);
    chk("sh_mis_rd", nrd, 0);
    chk("sh_mis_wr", nwr, 0);
    idle_cycle();

    run(3'b111, 32'd4, 16'd0, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("ill_done_cyc", done_cyc, 1);
    chk("ill_err", {31'd0, err_v}, 32'd1);
    chk("ill_rdwr", nrd + nwr, 0);
    idle_cycle();

    run(3'b011, 32'd4, 16'd2, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("sw_mis_err", {31'd0, err_v}, 32'd1);
    chk("sw_mis_wr", nwr, 0);
    idle_cycle();

    run(3'b010, 32'd4, 16'd1, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("swl1_wdata", wdata, 32'h1122aabb);
    run(3'b110, 32'd4, 16'd1, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("swr1_wdata", wdata, 32'hbbccdd44);
    run(3'b010, 32'd4, 16'd2, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("swl2_wdata", wdata, 32'h11aabbcc);
    run(3'b110, 32'd4, 16'd3, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("swr3_wdata", wdata, 32'hdd223344);
    idle_cycle();

    run(3'b010, 32'd4, 16'd3, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("swl3_nrd", nrd, 0);
    chk("swl3_wdata", wdata, 32'haabbccdd);
    chk("swl3_done_cyc", done_cyc, 2);
    run(3'b110, 32'd4, 16'd0, 32'haabbccdd, 32'h11223344, 0, 0);
    chk("swr0_nrd", nrd, 0);
    chk("swr0_wdata", wdata, 32'haabbccdd);
    chk("swr0_done_cyc", done_cyc, 2);
    idle_cycle();

    run(3'b011, 32'hfffffffc, 16'd4, 32'hdeadbeef, 32'h0, 0, 3);
    chk("sw_nrd", nrd, 0);
    chk("sw_addr", {2'd0, wr_addr}, 32'd0);
    chk("sw_wdata", wdata, 32'hdeadbeef);
    chk("sw_wr_cyc", wr_cyc, 1);
    chk("sw_nwr", nwr, 4);
    chk("sw_stable", {31'd0, unstable}, 32'd0);
    chk("sw_done_cyc", done_cyc, 5);
    // Next request issued in the done cycle.
    run(3'b000, 32'd0, 16'hffff, 32'h00000055, 32'h11223344, 0, 0);
    chk("b2b_addr", {2'd0, rd_addr}, 32'h3fffffff);
    chk("b2b_wdata", wdata, 32'h55223344);
    chk("b2b_done_cyc", done_cyc, 3);
    idle_cycle();

    run(3'b000, 32'd8, 16'd2, 32'h000000ee, 32'h11223344, 2, 1);
    chk("rwait_wr_cyc", wr_cyc, 4);
    chk("rwait_wdata", wdata, 32'h11ee3344);
    chk("rwait_stable", {31'd0, unstable}, 32'd0);
    chk("rwait_done_cyc", done_cyc, 6);
    idle_cycle();

`ifdef STORE_CONV_TIMEOUT_EN
    run(3'b000, 32'd4, 16'd1, 32'haabbccdd, 32'h11223344, -1, 0);
    chk("to_rd_nrd", nrd, 4);
    chk("to_rd_done_cyc", done_cyc, 5);
    chk("to_rd_err", {31'd0, err_v}, 32'd1);
    chk("to_rd_nwr", nwr, 0);
    idle_cycle();
    run(3'b011, 32'd4, 16'd0, 32'haabbccdd, 32'h0, 0, -1);
    chk("to_wr_nwr", nwr, 4);
    chk("to_wr_done_cyc", done_cyc, 5);
    chk("to_wr_err", {31'd0, err_v}, 32'd1);
    idle_cycle();
`endif

    // Reset during READ abandons the store silently.
    req = 1'b1; func = 3'b000; base = 32'd4; offset = 16'd0; rin = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_rd_pre", {31'd0, mem_rd}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_rd", {31'd0, mem_rd}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    seen = done | mem_wr;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | done | mem_wr | mem_rd;
    end
    chk("rstmid_quiet", {31'd0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
